// File: rtl/counter_event_fifo.sv
// Event collector: captures each counter's value (and optionally a timestamp) on a rising done-status
// edge and queues it in a FIFO drained over valid/ready. Timestamp support: define COUNTER_EVENT_STAMP_EN.
module counter_event_fifo #(
    parameter int SUB_NUMBER = 2,
    parameter int DEPTH      = 4,
    parameter int DATA_W     = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [SUB_NUMBER-1:0]        in_status,
    input  logic [SUB_NUMBER*DATA_W-1:0] in_data,
    input  logic                         rd_ready,
    input  logic                         clr_lost,
    output logic                         rd_valid,
    output logic [3:0]                   rd_id,
    output logic [DATA_W-1:0]            rd_data,
    output logic [31:0]                  rd_stamp,
    output logic [6:0]                   level,
    output logic [SUB_NUMBER-1:0]        lost
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SUB_NUMBER-1:0] prev_status;
    logic [SUB_NUMBER-1:0] pending;
    logic [SUB_NUMBER-1:0] rise;
    logic [SUB_NUMBER-1:0] grant;
    logic [SUB_NUMBER-1:0] pushed;
    logic [SUB_NUMBER-1:0] lost_set;
    logic [DATA_W-1:0]     cap_data [SUB_NUMBER];

    logic [3:0]            mem_id   [DEPTH];
    logic [DATA_W-1:0]     mem_data [DEPTH];
    logic [AW-1:0]         wp;
    logic [AW-1:0]         rp;
    logic [6:0]            count;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic [3:0]            win_id;
    logic [DATA_W-1:0]     win_data;

    assign rise     = in_status & ~prev_status;
    // Isolate the lowest set pending bit: fixed priority, lowest index wins.
    assign grant    = pending & (~pending + SUB_NUMBER'(1));
    assign full     = (count == 7'(DEPTH));
    assign rd_valid = (count != 7'd0);
    assign pop      = rd_valid & rd_ready;
    assign push     = (|pending) & (~full | pop);
    assign pushed   = grant & {SUB_NUMBER{push}};
    assign lost_set = rise & pending & ~pushed;
    assign level    = count;
    assign rd_id    = rd_valid ? mem_id[rp]   : 4'd0;
    assign rd_data  = rd_valid ? mem_data[rp] : '0;

    always_comb begin
        win_id   = 4'd0;
        win_data = '0;
        for (int i = 0; i < SUB_NUMBER; i++) begin
            if (grant[i]) begin
                win_id   = 4'(i);
                win_data = cap_data[i];
            end
        end
    end

    // Control state: edge history, pending flags, sticky loss, FIFO pointers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_status <= '0;
            pending     <= '0;
            lost        <= '0;
            wp          <= '0;
            rp          <= '0;
            count       <= 7'd0;
        end else begin
            prev_status <= in_status;
            pending     <= rise | (pending & ~pushed);
            lost        <= lost_set | (lost & ~{SUB_NUMBER{clr_lost}});
            if (push)
                wp <= wp + AW'(1);
            if (pop)
                rp <= rp + AW'(1);
            if (push && !pop)
                count <= count + 7'd1;
            else if (pop && !push)
                count <= count - 7'd1;
        end
    end

    // Capture and FIFO storage; a push reads the old capture while a same-cycle rise reloads it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SUB_NUMBER; i++) begin
            if (rise[i])
                cap_data[i] <= in_data[i*DATA_W +: DATA_W];
        end
        if (push) begin
            mem_id[wp]   <= win_id;
            mem_data[wp] <= win_data;
        end
    end

`ifdef COUNTER_EVENT_STAMP_EN
    logic [31:0] stamp;
    logic [31:0] cap_stamp [SUB_NUMBER];
    logic [31:0] mem_stamp [DEPTH];
    logic [31:0] win_stamp;

    always_comb begin
        win_stamp = 32'd0;
        for (int i = 0; i < SUB_NUMBER; i++) begin
            if (grant[i])
                win_stamp = cap_stamp[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            stamp <= 32'd0;
        else
            stamp <= stamp + 32'd1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < SUB_NUMBER; i++) begin
            if (rise[i])
                cap_stamp[i] <= stamp;
        end
        if (push)
            mem_stamp[wp] <= win_stamp;
    end

    assign rd_stamp = rd_valid ? mem_stamp[rp] : 32'd0;
`else
    assign rd_stamp = 32'd0;
`endif

endmodule
